// File: rtl/image_blitter.sv
// image_blitter: streams a W x H rectangle from a synchronous ROM into
// the vga_adapter plot port, with screen-edge clipping and colour keying.
module image_blitter #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int COLOUR_W    = 12,
  parameter int ADDR_W      = 15,
  parameter int ROM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          x0,
  input  logic [7:0]          y0,
  input  logic [7:0]          width,
  input  logic [7:0]          height,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                key_en,
  input  logic [COLOUR_W-1:0] key_colour,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [7:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
  localparam int L = ROM_LATENCY;
  localparam logic [1:0] DRAIN_LAST = 2'(L);
  localparam logic [8:0] MAX_X = 9'(SCREEN_W);
  localparam logic [8:0] MAX_Y = 9'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE, FETCH, DRAIN, FINISH
  } state_t;

  state_t                state_q;
  logic [7:0]            x0_q, y0_q;
  logic [7:0]            w_q, h_q;
  logic [7:0]            col_q, row_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  key_en_q;
  logic [COLOUR_W-1:0]   key_q;
  logic                  iss_v_q;
  logic                  busy_q, done_q;
  logic [1:0]            drain_q;
  logic                  last_pix;

  assign last_pix = (col_q == w_q - 8'd1) &&
                    (row_q == h_q - 8'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      key_en_q <= 1'b0;
      key_q    <= '0;
      iss_v_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drain_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      iss_v_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          x0_q     <= x0;
          y0_q     <= y0;
          w_q      <= width;
          h_q      <= height;
          key_en_q <= key_en;
          key_q    <= key_colour;
          col_q    <= '0;
          row_q    <= '0;
          if (width == 8'd0 || height == 8'd0) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            iss_v_q <= 1'b1;
            addr_q  <= base_addr;
          end
        end
        FETCH: if (last_pix) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end else begin
          iss_v_q <= 1'b1;
          addr_q  <= addr_q + ADDR_W'(1);
          if (col_q == w_q - 8'd1) begin
            col_q <= '0;
            row_q <= row_q + 8'd1;
          end else begin
            col_q <= col_q + 8'd1;
          end
        end
        // covers the ROM delay line plus the output register
        DRAIN: if (drain_q == DRAIN_LAST) begin
          state_q <= FINISH;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q + 2'd1;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [L-1:0][7:0] dl_col_q, dl_col_d;
  logic [L-1:0][7:0] dl_row_q, dl_row_d;
  logic [L-1:0]      dl_v_q, dl_v_d;

  always_comb begin
    dl_col_d    = dl_col_q;
    dl_row_d    = dl_row_q;
    dl_v_d      = dl_v_q;
    dl_col_d[0] = col_q;
    dl_row_d[0] = row_q;
    dl_v_d[0]   = iss_v_q;
    for (int i = 1; i < L; i++) begin
      dl_col_d[i] = dl_col_q[i-1];
      dl_row_d[i] = dl_row_q[i-1];
      dl_v_d[i]   = dl_v_q[i-1];
    end
  end

  logic [8:0]          x9, y9;
  logic [7:0]          x_q, x_d, y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;

  assign x9 = {1'b0, x0_q} + {1'b0, dl_col_q[L-1]};
  assign y9 = {1'b0, y0_q} + {1'b0, dl_row_q[L-1]};

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    if (dl_v_q[L-1]) begin
      x_d      = x9[7:0];
      y_d      = y9[7:0];
      colour_d = rom_q;
      plot_d   = (x9 < MAX_X) && (y9 < MAX_Y) &&
                 !(key_en_q && (rom_q == key_q));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dl_col_q <= '0;
      dl_row_q <= '0;
      dl_v_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      dl_col_q <= dl_col_d;
      dl_row_q <= dl_row_d;
      dl_v_q   <= dl_v_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign rom_addr = addr_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: three blitters (ROM latency 1..3) on shared stimulus,
// checked every cycle against a pixel-list model of each blit.
module tb_image_blitter;
  localparam int NL = 3;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x0 = '0, y0 = '0;
  logic [7:0]  width = '0, height = '0;
  logic [14:0] base = '0;
  logic        key_en = 1'b0;
  logic [11:0] key_col = '0;

  logic [14:0] rom_addr_w [NL];
  logic [11:0] rom_q_w [NL];
  logic [7:0]  x_w [NL];
  logic [7:0]  y_w [NL];
  logic [11:0] col_w [NL];
  logic        plot_w [NL];
  logic        busy_w [NL];
  logic        done_w [NL];

  logic [11:0] mem [0:32767];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    logic [11:0] pipe [g+1];
    always @(posedge clock) begin
      pipe[0] <= mem[rom_addr_w[g]];
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end
    assign rom_q_w[g] = pipe[g];

    image_blitter #(.ROM_LATENCY(g + 1)) u_dut (
      .clock      (clock),
      .reset      (rst),
      .start      (start),
      .x0         (x0),
      .y0         (y0),
      .width      (width),
      .height     (height),
      .base_addr  (base),
      .key_en     (key_en),
      .key_colour (key_col),
      .rom_addr   (rom_addr_w[g]),
      .rom_q      (rom_q_w[g]),
      .x          (x_w[g]),
      .y          (y_w[g]),
      .colour     (col_w[g]),
      .plot       (plot_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g])
    );
  end

  typedef struct {
    int          cyc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic        p;
  } pix_t;

  pix_t        expq [NL][$];
  int          checks = 0, failures = 0, cyc = 0;
  int          free_at [NL], bfrom [NL], bto [NL];
  int          done_at [NL], rem [NL];
  logic [14:0] exp_addr [NL];
  int          plot_cnt [NL], done_cnt [NL];
  int          busy_cnt [NL], centre_cnt [NL];
  logic [7:0]  last_x [NL], last_y [NL];
  int          sp [NL], sd [NL], sb [NL], sc [NL];
  logic [7:0]  cx = '0, cy = '0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s lat=%0d actual=%0h required=%0h t=%0t",
               nm, i + 1, act, req, $time);
    end
  endtask

  // A blit of N pixels accepted at edge c: pixel k shows after edge
  // c+k+L+1, busy spans edges c..c+N+L, done follows at c+N+L+1.
  task automatic accept(input int i, input int c);
    int n, l, col, row, x9, y9;
    logic [11:0] q;
    pix_t p;
    l = i + 1;
    n = int'(width) * int'(height);
    if (n == 0) begin
      done_at[i] = c;
      free_at[i] = c + 2;
    end else begin
      bfrom[i]    = c;
      bto[i]      = c + n + l;
      done_at[i]  = c + n + l + 1;
      free_at[i]  = c + n + l + 3;
      exp_addr[i] = base;
      rem[i]      = n - 1;
      for (int k = 0; k < n; k++) begin
        col   = k % int'(width);
        row   = k / int'(width);
        x9    = int'(x0) + col;
        y9    = int'(y0) + row;
        q     = mem[15'(int'(base) + k)];
        p.cyc = c + k + l + 1;
        p.x   = 8'(x9);
        p.y   = 8'(y9);
        p.c   = q;
        p.p   = (x9 < 160) && (y9 < 120) &&
                !(key_en && q == key_col);
        expq[i].push_back(p);
      end
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clock);
      cyc++;
      for (int i = 0; i < NL; i++) begin
        if (rst) begin
          expq[i].delete();
          free_at[i]  = 0;
          bfrom[i]    = -1;
          bto[i]      = -1;
          done_at[i]  = -1;
          rem[i]      = 0;
          exp_addr[i] = '0;
        end else begin
          if (rem[i] > 0) begin
            exp_addr[i]++;
            rem[i]--;
          end
          if (start && cyc >= free_at[i]) accept(i, cyc);
        end
      end
    end
  endtask

  task automatic compare_loop();
    pix_t p;
    forever begin
      @(negedge clock);
      if (!rst) begin
        for (int i = 0; i < NL; i++) begin
          chk("busy", i, 32'(busy_w[i]),
              32'(cyc >= bfrom[i] && cyc <= bto[i]));
          chk("done", i, 32'(done_w[i]), 32'(cyc == done_at[i]));
          chk("rom_addr", i, 32'(rom_addr_w[i]), 32'(exp_addr[i]));
          if (expq[i].size() > 0 && expq[i][0].cyc == cyc) begin
            p = expq[i].pop_front();
            chk("plot", i, 32'(plot_w[i]), 32'(p.p));
            chk("x", i, 32'(x_w[i]), 32'(p.x));
            chk("y", i, 32'(y_w[i]), 32'(p.y));
            chk("colour", i, 32'(col_w[i]), 32'(p.c));
          end else begin
            chk("plot_idle", i, 32'(plot_w[i]), 32'(0));
          end
          if (plot_w[i]) begin
            plot_cnt[i]++;
            last_x[i] = x_w[i];
            last_y[i] = y_w[i];
            if (x_w[i] == cx && y_w[i] == cy) centre_cnt[i]++;
          end
          if (busy_w[i]) busy_cnt[i]++;
          if (done_w[i]) done_cnt[i]++;
        end
      end
    end
  endtask

  task automatic snap();
    for (int i = 0; i < NL; i++) begin
      sp[i] = plot_cnt[i];
      sd[i] = done_cnt[i];
      sb[i] = busy_cnt[i];
      sc[i] = centre_cnt[i];
    end
  endtask

  task automatic blit(input logic [7:0] bx, input logic [7:0] by,
                      input logic [7:0] bw, input logic [7:0] bh,
                      input logic [14:0] bb, input logic bk,
                      input logic [11:0] bkc);
    @(posedge clock); #2;
    x0 = bx; y0 = by; width = bw; height = bh;
    base = bb; key_en = bk; key_col = bkc;
    start = 1'b1;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int  n;
    bit  all;
    n = 0;
    do begin
      @(posedge clock); #2;
      n++;
      all = 1'b1;
      for (int i = 0; i < NL; i++)
        if (done_cnt[i] <= sd[i]) all = 1'b0;
    end while (!all && n < bound);
    checks++;
    if (!all) begin
      failures++;
      $display("FAIL done_timeout waited=%0d cycles t=%0t", n, $time);
    end
    repeat (3) @(posedge clock);
    #2;
  endtask

  task automatic res(input string nm, input int i,
                     input int act, input int req);
    chk(nm, i, 32'(act), 32'(req));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      plot_cnt[i] = 0; done_cnt[i] = 0;
      busy_cnt[i] = 0; centre_cnt[i] = 0;
      free_at[i] = 0; bfrom[i] = -1; bto[i] = -1;
      done_at[i] = -1; rem[i] = 0; exp_addr[i] = '0;
      last_x[i] = '0; last_y[i] = '0;
    end
    for (int a = 0; a < 32768; a++) mem[a] = 12'($urandom);
    fork
      model_loop();
      compare_loop();
      begin
        #5000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clock);
    #2;
    for (int i = 0; i < NL; i++) begin
      chk("rst_rom_addr", i, 32'(rom_addr_w[i]), 32'(0));
      chk("rst_x", i, 32'(x_w[i]), 32'(0));
      chk("rst_y", i, 32'(y_w[i]), 32'(0));
      chk("rst_colour", i, 32'(col_w[i]), 32'(0));
      chk("rst_plot", i, 32'(plot_w[i]), 32'(0));
      chk("rst_busy", i, 32'(busy_w[i]), 32'(0));
      chk("rst_done", i, 32'(done_w[i]), 32'(0));
    end
    rst = 1'b0;

    snap();
    blit(8'd0, 8'd0, 8'd160, 8'd120, 15'd0, 1'b0, 12'h0);
    wait_done(20000);
    for (int i = 0; i < NL; i++) begin
      res("s1_plots", i, plot_cnt[i] - sp[i], 19200);
      res("s1_last_x", i, int'(last_x[i]), 159);
      res("s1_last_y", i, int'(last_y[i]), 119);
      res("s1_rom_addr", i, int'(rom_addr_w[i]), 19199);
      res("s1_dones", i, done_cnt[i] - sd[i], 1);
      res("s1_busy", i, busy_cnt[i] - sb[i], 19200 + i + 2);
    end

    snap();
    blit(8'd158, 8'd119, 8'd4, 8'd2, 15'd100, 1'b0, 12'h0);
    wait_done(100);
    for (int i = 0; i < NL; i++) begin
      res("s2_plots", i, plot_cnt[i] - sp[i], 2);
      res("s2_last_x", i, int'(last_x[i]), 159);
      res("s2_last_y", i, int'(last_y[i]), 119);
      res("s2_rom_addr", i, int'(rom_addr_w[i]), 107);
      res("s2_busy", i, busy_cnt[i] - sb[i], 8 + i + 2);
      res("s2_dones", i, done_cnt[i] - sd[i], 1);
    end

    for (int k = 0; k < 9; k++)
      if (k != 4 && mem[200+k] == 12'hABC) mem[200+k] = 12'hABD;
    mem[204] = 12'hABC;
    cx = 8'd21;
    cy = 8'd31;
    snap();
    blit(8'd20, 8'd30, 8'd3, 8'd3, 15'd200, 1'b1, 12'hABC);
    wait_done(100);
    for (int i = 0; i < NL; i++) begin
      res("s3_plots", i, plot_cnt[i] - sp[i], 8);
      res("s3_centre", i, centre_cnt[i] - sc[i], 0);
      res("s3_dones", i, done_cnt[i] - sd[i], 1);
    end
    snap();
    blit(8'd20, 8'd30, 8'd3, 8'd3, 15'd200, 1'b0, 12'hABC);
    wait_done(100);
    for (int i = 0; i < NL; i++) begin
      res("s3b_plots", i, plot_cnt[i] - sp[i], 9);
      res("s3b_centre", i, centre_cnt[i] - sc[i], 1);
    end

    snap();
    blit(8'd40, 8'd40, 8'd0, 8'd5, 15'd500, 1'b0, 12'h0);
    wait_done(20);
    for (int i = 0; i < NL; i++) begin
      res("s4_plots", i, plot_cnt[i] - sp[i], 0);
      res("s4_busy", i, busy_cnt[i] - sb[i], 0);
      res("s4_dones", i, done_cnt[i] - sd[i], 1);
      res("s4_rom_addr", i, int'(rom_addr_w[i]), 208);
    end

    snap();
    blit(8'd10, 8'd10, 8'd5, 8'd3, 15'd300, 1'b0, 12'h0);
    repeat (6) @(posedge clock);
    blit(8'd50, 8'd50, 8'd7, 8'd7, 15'd400, 1'b0, 12'h0);
    wait_done(100);
    for (int i = 0; i < NL; i++) begin
      res("s5_plots", i, plot_cnt[i] - sp[i], 15);
      res("s5_dones", i, done_cnt[i] - sd[i], 1);
      res("s5_last_x", i, int'(last_x[i]), 14);
      res("s5_last_y", i, int'(last_y[i]), 12);
      res("s5_rom_addr", i, int'(rom_addr_w[i]), 314);
    end

    snap();
    blit(8'd5, 8'd5, 8'd20, 8'd20, 15'd1000, 1'b0, 12'h0);
    repeat (30) @(posedge clock);
    #2;
    for (int i = 0; i < NL; i++) begin
      chk("s6_busy_pre", i, 32'(busy_w[i]), 32'(1));
      chk("s6_plot_pre", i, 32'(plot_w[i]), 32'(1));
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < NL; i++) begin
      chk("s6_plot_rst", i, 32'(plot_w[i]), 32'(0));
      chk("s6_busy_rst", i, 32'(busy_w[i]), 32'(0));
      chk("s6_done_rst", i, 32'(done_w[i]), 32'(0));
    end
    repeat (2) @(posedge clock);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NL; i++)
      res("s6_no_done", i, done_cnt[i] - sd[i], 0);
    snap();
    blit(8'd0, 8'd0, 8'd2, 8'd2, 15'd5, 1'b0, 12'h0);
    wait_done(50);
    for (int i = 0; i < NL; i++) begin
      res("s6_plots", i, plot_cnt[i] - sp[i], 4);
      res("s6_dones", i, done_cnt[i] - sd[i], 1);
      res("s6_rom_addr", i, int'(rom_addr_w[i]), 8);
    end

    for (int t = 0; t < 1500; t++) begin
      @(posedge clock); #2;
      start  = ($urandom_range(0, 5) == 0);
      width  = 8'($urandom_range(0, 9));
      height = 8'($urandom_range(0, 5));
      x0     = $urandom_range(0, 1) ? 8'($urandom_range(150, 165))
                                    : 8'($urandom);
      y0     = $urandom_range(0, 1) ? 8'($urandom_range(110, 125))
                                    : 8'($urandom);
      base   = $urandom_range(0, 3) == 0 ? 15'd32760 : 15'($urandom);
      key_en = 1'($urandom_range(0, 1));
      key_col = mem[15'(int'(base) + int'($urandom_range(0, 3)))];
    end
    @(posedge clock); #2;
    width = 8'd2; height = 8'd2; x0 = 8'd100; y0 = 8'd100;
    key_en = 1'b0; start = 1'b1;
    repeat (60) @(posedge clock);
    #2;
    start = 1'b0;

    begin
      int  n;
      bit  quiet;
      n = 0;
      do begin
        @(posedge clock); #2;
        n++;
        quiet = 1'b1;
        for (int i = 0; i < NL; i++)
          if (busy_w[i] || cyc < free_at[i]) quiet = 1'b0;
      end while (!quiet && n < 300);
      checks++;
      if (!quiet) begin
        failures++;
        $display("FAIL quiet_timeout waited=%0d cycles", n);
      end
    end
    for (int i = 0; i < NL; i++)
      res("pending_pixels", i, expq[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
